// File: rtl/du_report_tx_pkg.sv
// Shared debug-unit constants: snapshot geometry, report FSM encoding and host-link mode bytes.
package du_report_tx_pkg;

  localparam int unsigned N_BITS_DATA = 8;
  localparam int unsigned NB_DATA     = 32;
  localparam int unsigned N_REGISTER  = 33;
  localparam int unsigned N_WORDS     = N_REGISTER + 1;
  localparam int unsigned NB_SEND     = N_WORDS * NB_DATA + N_BITS_DATA;
  localparam int unsigned N_BYTES     = NB_SEND / N_BITS_DATA;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StSend = ST_SEND,
    StWait = ST_WAIT,
    StDone = ST_DONE
  } state_e;

  localparam logic [7:0] mode_step_to_step = 8'h0F;
  localparam logic [7:0] mode_continue     = 8'hF0;

  // Byte that makes the whole report (data plus this byte) sum to zero mod 256.
  function automatic logic [7:0] checksum_byte(input logic [7:0] sum);
    return 8'h00 - sum;
  endfunction

endpackage

// File: rtl/du_byte_mux.sv
// Snapshot shift register: parallel load, right shift by one byte, exposes the byte that
// becomes current after the next clock edge.
module du_byte_mux
  import du_report_tx_pkg::*;
#(
  parameter int unsigned Width = NB_SEND,
  parameter int unsigned ByteW = N_BITS_DATA
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load,
  input  logic             shift,
  input  logic [Width-1:0] snapshot,
  output logic [ByteW-1:0] next_byte
);

  logic [Width-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = snapshot;
    end else if (shift) begin
      shreg_d = shreg_q >> ByteW;
    end
  end

  // Looking at the next-state value lets the caller register the byte on entry to SEND.
  assign next_byte = shreg_d[ByteW-1:0];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/du_report_tx.sv
// Debug-unit report serializer: streams the captured snapshot LSB byte first over a UART
// tx handshake. Optional trailing checksum byte when DU_REPORT_CHECKSUM_EN is defined.
module du_report_tx
  import du_report_tx_pkg::*;
(
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [NB_SEND-1:0]     data_send_i,
  input  logic                   tx_done_tick_i,
  output logic                   tx_start_o,
  output logic [N_BITS_DATA-1:0] tx_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned NB_CNT = $clog2(N_BYTES + 2);
`ifdef DU_REPORT_CHECKSUM_EN
  localparam int unsigned N_TOTAL = N_BYTES + 1;
`else
  localparam int unsigned N_TOTAL = N_BYTES;
`endif
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_TOTAL);

  state_e                 state_q, state_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;
  logic [N_BITS_DATA-1:0] tx_data_q, tx_data_d;
  logic                   load, shift;
  logic [N_BITS_DATA-1:0] next_byte;

`ifdef DU_REPORT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  du_byte_mux #(
    .Width(NB_SEND),
    .ByteW(N_BITS_DATA)
  ) u_byte_mux (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load     (load),
    .shift    (shift),
    .snapshot (data_send_i),
    .next_byte(next_byte)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          load      = 1'b1;
          cnt_d     = '0;
          tx_data_d = next_byte;
          state_d   = StSend;
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (tx_done_tick_i) begin
          shift = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LAST_CNT) begin
            state_d = StDone;
          end else begin
            state_d   = StSend;
            tx_data_d = next_byte;
`ifdef DU_REPORT_CHECKSUM_EN
            if (cnt_d == NB_CNT'(N_BYTES)) begin
              tx_data_d = checksum_byte(csum_q);
            end
`endif
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef DU_REPORT_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && start_i) begin
      csum_d = '0;
    end else if (state_q == StSend) begin
      csum_d = csum_q + tx_data_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_start_o = (state_q == StSend);
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q == StSend) || (state_q == StWait);
  assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_du_report_tx.sv
// Self-checking bench for du_report_tx: table of report scenarios plus randomized snapshots,
// checked against a byte-stream model built from the snapshot.
module tb_du_report_tx;

  localparam int NB_SEND = 1096;
  localparam int N_BYTES = 137;
`ifdef DU_REPORT_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int N_TOTAL = N_BYTES + CK;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [NB_SEND-1:0] data_send;
  logic               tick;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  du_report_tx dut (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .start_i       (start),
    .data_send_i   (data_send),
    .tx_done_tick_i(tick),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .busy_o        (busy),
    .done_o        (done)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit spur_en  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [NB_SEND-1:0] snap;
    logic [NB_SEND-1:0] snap2;
    int                 gap;
    int                 busy_at;
    int                 abort_at;
    int                 long_at;
    int                 exp_bytes;
    logic [7:0]         exp_first;
    logic [7:0]         exp_last;
    int                 exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB_SEND-1:0] ramp(input bit inv);
    logic [NB_SEND-1:0] r;
    for (int k = 0; k < N_BYTES; k++) r[8*k +: 8] = inv ? 8'(255 - k) : 8'(k);
    return r;
  endfunction

  function automatic logic [NB_SEND-1:0] ends_snap();
    logic [NB_SEND-1:0] r;
    r = '0;
    r[7:0] = 8'hA5;
    r[NB_SEND-8 +: 8] = 8'h3C;
    return r;
  endfunction

  // Expected stream: bytes in ascending order, then the negated sum when enabled.
  task automatic build_model(input logic [NB_SEND-1:0] s);
    int sum;
    exp_q.delete();
    sum = 0;
    for (int k = 0; k < N_BYTES; k++) begin
      exp_q.push_back(s[8*k +: 8]);
      sum += int'(s[8*k +: 8]);
    end
    if (CK != 0) exp_q.push_back(8'((256 - (sum % 256)) % 256));
  endtask

  // Must be entered at a falling edge; acts as the UART tx and collects bytes into rx_q.
  task automatic run_report(input logic [NB_SEND-1:0] snap, input logic [NB_SEND-1:0] snap2,
                            input int gap, input int busy_at, input int abort_at,
                            input int long_at, output int ndone);
    int wait_cnt, unstable, extra, budget;
    bit fin, tick_prev;
    logic [7:0] held;
    rx_q.delete();
    ndone = 0; wait_cnt = -1; fin = 0; tick_prev = 0; unstable = 0; extra = 0; held = '0;
    budget = N_TOTAL * (gap + 3) + 1300;
    start = 1'b1;
    data_send = snap;
    @(negedge clk);
    start = 1'b0;
    check("start_to_tx_start", {busy, tx_start}, 2'b11);
    for (int c = 0; c < budget && !fin; c++) begin
      tick = 1'b0;
      start = 1'b0;
      if (tick_prev) check("tick_to_next", tx_start | done, 1'b1);
      tick_prev = 0;
      if (abort_at >= 0 && !tx_start && busy && rx_q.size() == abort_at + 1) begin
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {tx_start, busy, done, tx_data}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fin = 1;
      end else if (done) begin
        ndone++;
        check("busy_with_done", busy, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        fin = 1;
      end else begin
        if (tx_start) begin
          if (wait_cnt >= 0) extra++;
          rx_q.push_back(tx_data);
          held = tx_data;
          wait_cnt = (rx_q.size() - 1 == long_at) ? 1000 : gap;
          if (rx_q.size() - 1 == busy_at) begin
            start = 1'b1;
            data_send = snap2;
          end
          if (spur_en) tick = 1'b1;
        end else if (busy) begin
          if (tx_data !== held) unstable++;
          if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
              tick = 1'b1;
              tick_prev = 1;
              wait_cnt = -1;
            end
          end
        end
        @(negedge clk);
      end
    end
    tick = 1'b0;
    check("report_finished", fin, 1'b1);
    check("data_stable", unstable, 0);
    check("no_extra_tx_start", extra, 0);
  endtask

  task automatic compare_stream(input int exp_bytes, input int ndone, input int exp_done);
    int mism;
    mism = 0;
    for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++)
      if (rx_q[k] !== exp_q[k]) mism++;
    check("byte_count", rx_q.size(), exp_bytes);
    check("stream_vs_model", mism, 0);
    check("done_pulses", ndone, exp_done);
  endtask

  initial begin
    int ndone, idle_bad;
    logic [NB_SEND-1:0] r;

    vecs[0] = '{ends_snap(), '0, 20, -1, -1, -1, N_TOTAL, 8'hA5, (CK != 0) ? 8'h1F : 8'h3C, 1};
    vecs[1] = '{ramp(0), '0, 2, -1, -1, -1, N_TOTAL, 8'h00, (CK != 0) ? 8'h9C : 8'h88, 1};
    vecs[2] = '{ramp(0), {NB_SEND{1'b1}}, 3, 40, -1, -1, N_TOTAL, 8'h00,
                (CK != 0) ? 8'h9C : 8'h88, 1};
    vecs[3] = '{ends_snap(), '0, 2, -1, 10, -1, 11, 8'hA5, 8'h00, 0};
    vecs[4] = '{ramp(1), '0, 1, -1, -1, -1, N_TOTAL, 8'hFF, (CK != 0) ? 8'hED : 8'h77, 1};
    vecs[5] = '{ramp(0), '0, 1, -1, -1, 5, N_TOTAL, 8'h00, (CK != 0) ? 8'h9C : 8'h88, 1};

    rst_n = 1'b0; start = 1'b0; tick = 1'b0; data_send = '0;
    repeat (5) @(negedge clk);
    check("reset_outputs", {tx_start, busy, done, tx_data}, '0);
    rst_n = 1'b1;

    // Idle: no start, one stray tick that must be ignored.
    idle_bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tick = (c == 50);
      if ({tx_start, busy, done, tx_data} != '0) idle_bad++;
    end
    tick = 1'b0;
    @(negedge clk);
    check("idle_outputs", idle_bad, 0);

    for (int v = 0; v < 6; v++) begin
      run_report(vecs[v].snap, vecs[v].snap2, vecs[v].gap, vecs[v].busy_at, vecs[v].abort_at,
                 vecs[v].long_at, ndone);
      build_model(vecs[v].snap);
      compare_stream(vecs[v].exp_bytes, ndone, vecs[v].exp_done);
      check("first_byte", rx_q.size() > 0 ? rx_q[0] : 8'hxx, vecs[v].exp_first);
      check("last_byte", rx_q.size() > 0 ? rx_q[rx_q.size()-1] : 8'hxx, vecs[v].exp_last);
    end

    spur_en = 1;
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < NB_SEND / 32; w++) r[32*w +: 32] = $urandom;
      r[NB_SEND-8 +: 8] = 8'($urandom);
      run_report(r, ~r, $urandom_range(1, 4), -1, -1, -1, ndone);
      build_model(r);
      compare_stream(N_TOTAL, ndone, 1);
    end
    spur_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
